res_pot_sched: RTL and testbench
================================

Name: res_pot_sched

Overview:
- Scheduler and serializer for the shared digital-potentiometer serial bus (ResCS/ResSck/ResSDI).
- Two requesters share the bus:
  - the frame-loop table load, which rewrites all NCH bias channels between frames;
  - single-channel writes from debug/host.
- Sits beside the readout sequencer. New frames start only while the sequencer grants a write window (Win), so pot updates never disturb INTG/SMPL/CNVRT.

Parameters:
- NCH, 6: channels per table load, 1..8; channel index = 3-bit pot address.
- CLK_DIV, 2: OSC_in cycles per ResSck half-period, 1..15.
- GAP_CYC, 4: minimum OSC_in cycles with ResCS high between frames, 1..15.

Ports:
- OSC_in in 1: single clock, all logic on its rising edge.
- RstN in 1: asynchronous active-low reset.
- Win in 1: sequencer write window; a new frame may start only while Win=1.
- TblReq in 1: table-load request, level, held until TblAck.
- TblData in 8*NCH: channel k data = TblData[8k+7:8k]; captured at accept.
- TblAck out 1: one-cycle pulse, table load complete.
- SglReq in 1: single-write request, level, held until SglAck.
- SglAddr in 3: pot address.
- SglData in 8: pot data.
- SglAck out 1: one-cycle pulse, single write complete.
- Busy out 1: high from accept of any request to its ack.
- ResCS out 1: pot chip select, active low.
- ResSck out 1: serial clock, idle low.
- ResSDI out 1: serial data.

Behaviour:
- Reset, asynchronous:
  - ResCS=1, ResSck=0, ResSDI=0, TblAck=0, SglAck=0, Busy=0.
  - State IDLE, channel index 0, fairness flag cleared.
  - Assertion mid-frame aborts immediately; the pot sees a truncated frame, which it ignores.
- Frame format: 11 bits, MSB first, addr[2:0] then data[7:0].
- SDI changes only while Sck is low; the pot samples on the Sck rising edge.
- States: IDLE, ARB, SETUP, SHIFT, HOLD, GAP.
  - IDLE: Busy=0. On TblReq or SglReq go to ARB; TblData or SglAddr/SglData are captured in that transition cycle.
  - ARB: pick the next frame.
    - If Win=0, stay in ARB.
    - Else load the 11-bit shift register, drive ResCS=0 and ResSDI=bit10, go to SETUP.
  - SETUP: CLK_DIV cycles, Sck low, then to SHIFT.
  - SHIFT: 11 bits, each Sck high for CLK_DIV cycles then low for CLK_DIV cycles; the next bit is presented on the falling edge.
  - HOLD: CLK_DIV cycles, Sck low; on exit ResCS=1.
  - GAP: GAP_CYC cycles. Then go to ARB if any work is pending, else IDLE.
- Frame timing: ResCS low exactly 24*CLK_DIV cycles; 11 rising Sck edges per frame.
- Table load: NCH frames, addresses 0..NCH-1 ascending. TblAck pulses in the cycle ResCS rises after the frame for address NCH-1.
- Single write: one frame. SglAck pulses in the cycle ResCS rises.
- Arbitration happens only at frame boundaries, in ARB.
  - A pending single write wins over the next table frame, unless the previous frame was a single write and a table frame is pending.
  - Result: strict alternation under contention. A table load is interrupted between channels and resumes at the next channel.
- Win drops mid-frame: the frame completes; the next frame waits in ARB.
- Requester rules:
  - A requester dropping Req before its ack is a protocol violation: the captured data is still sent and the ack is still issued.
  - Req still high in the cycle after its ack is treated as a new request.
- Both acks in the same cycle is impossible; frames never overlap.

Optional Feature:
- Macro RES_POT_SHADOW_EN.
- Defined:
  - Adds an 8x8 shadow array plus valid bits, cleared by reset; a shadow entry is written at HOLD exit.
  - Table frames whose data equals a valid shadow entry are skipped: no CS activity, zero cycles, indexing continues.
  - Single writes are never skipped.
  - Adds ports ShAddr (in 3) and ShData (out 8); ShData is a combinational read of the shadow array.
- Undefined: no shadow, no extra ports, every table frame is sent.

Decomposition:
- Package res_pot_pkg holds:
  - state enum;
  - FRAME_BITS=11, ADDR_BITS=3, DATA_BITS=8;
  - a helper that builds the frame word {addr, data}.
- Sub-module res_pot_shift: SETUP/SHIFT/HOLD timing, Sck divider and bit counter; start/done handshake.
- The top holds the arbiter, table indexing and the optional shadow.

Test Plan:
- CLK_DIV=1, Win=1, SglReq with addr=5, data=0xA3 → one frame: ResCS low 24 cycles; SDI bits sampled on rising edges are 101_10100011; SglAck once.
- TblReq with NCH=6, TblData=48'hFF00CD200000, Win=1 → 6 frames, addresses 0..5 with data 00,00,20,CD,00,FF; TblAck once after the 6th; ResCS high ≥GAP_CYC between frames.
- Table load active; SglReq (addr 7, data 0x11) raised during frame 2 → order: ch0, ch1, ch2, single, ch3, ch4, ch5; SglAck precedes TblAck.
- Win=0 while TblReq is pending → no ResCS activity. Win pulled low mid-frame → that frame completes, next waits; raise Win → resumes at the next address.
- RstN asserted during SHIFT bit 4 → same cycle ResCS=1, Sck=0, Busy=0. After release, a new SglReq produces a full clean frame.
- With RES_POT_SHADOW_EN:
  - repeat an identical table load → zero frames, TblAck still pulses;
  - change only ch3 → exactly one frame (addr 3);
  - ShAddr=3 returns the new value.

Source files
------------

// File: rtl/res_pot_pkg.sv
// Shared types and frame helpers for the digital-pot serial bus scheduler.
package res_pot_pkg;
    typedef enum logic [2:0] {IDLE, ARB, SETUP, SHIFT, HOLD, GAP} pot_st_e;

    localparam int FRAME_BITS = 11;
    localparam int ADDR_BITS  = 3;
    localparam int DATA_BITS  = 8;

    function automatic logic [FRAME_BITS-1:0] mk_frame(input logic [ADDR_BITS-1:0] addr,
                                                       input logic [DATA_BITS-1:0] data);
        return {addr, data};
    endfunction
endpackage

// File: rtl/res_pot_sched_if.sv
// Requester handshakes and pot serial pins of res_pot_sched.
// RES_POT_SHADOW_EN adds the ShAddr/ShData shadow read port.
interface res_pot_sched_if #(parameter int NCH = 6);
    logic             Win;
    logic             TblReq;
    logic [8*NCH-1:0] TblData;
    logic             TblAck;
    logic             SglReq;
    logic [2:0]       SglAddr;
    logic [7:0]       SglData;
    logic             SglAck;
    logic             Busy;
    logic             ResCS;
    logic             ResSck;
    logic             ResSDI;
`ifdef RES_POT_SHADOW_EN
    logic [2:0]       ShAddr;
    logic [7:0]       ShData;

    modport slave  (input  Win, TblReq, TblData, SglReq, SglAddr, SglData, ShAddr,
                    output TblAck, SglAck, Busy, ResCS, ResSck, ResSDI, ShData);
    modport master (output Win, TblReq, TblData, SglReq, SglAddr, SglData, ShAddr,
                    input  TblAck, SglAck, Busy, ResCS, ResSck, ResSDI, ShData);
`else
    modport slave  (input  Win, TblReq, TblData, SglReq, SglAddr, SglData,
                    output TblAck, SglAck, Busy, ResCS, ResSck, ResSDI);
    modport master (output Win, TblReq, TblData, SglReq, SglAddr, SglData,
                    input  TblAck, SglAck, Busy, ResCS, ResSck, ResSDI);
`endif
endinterface

// File: rtl/res_pot_shift.sv
// One pot frame: SETUP, 11 Sck periods MSB first, HOLD. ResCS low for 24*CLK_DIV cycles.
module res_pot_shift
    import res_pot_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic                  gclk,
    input  logic                  grst_n,
    input  logic                  start,
    input  logic [FRAME_BITS-1:0] frame,
    output logic                  done,
    output logic                  cs,
    output logic                  sck,
    output logic                  sdi
);
    localparam logic [3:0] DIV_M1   = 4'(CLK_DIV - 1);
    localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

    pot_st_e               ph, ph_n;
    logic [3:0]            cnt, bitn;
    logic [FRAME_BITS-2:0] sr;
    logic                  tick;

    assign tick = (cnt == DIV_M1);
    assign done = (ph == HOLD) && tick;

    always_ff @(posedge gclk or negedge grst_n)
        if (!grst_n) ph <= IDLE;
        else         ph <= ph_n;

    always_comb begin
        ph_n = ph;
        case (ph)
            IDLE:    if (start) ph_n = SETUP;
            SETUP:   if (tick) ph_n = SHIFT;
            SHIFT:   if (tick && !sck && bitn == LAST_BIT) ph_n = HOLD;
            HOLD:    if (tick) ph_n = IDLE;
            default: ph_n = IDLE;
        endcase
    end

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            cnt  <= '0;
            bitn <= '0;
            sr   <= '0;
            cs   <= 1'b1;
            sck  <= 1'b0;
            sdi  <= 1'b0;
        end else begin
            cnt <= (ph == IDLE || tick) ? 4'd0 : cnt + 4'd1;
            case (ph)
                IDLE: if (start) begin
                    sr  <= frame[FRAME_BITS-2:0];
                    cs  <= 1'b0;
                    sdi <= frame[FRAME_BITS-1];
                end
                SETUP: if (tick) begin
                    sck  <= 1'b1;
                    bitn <= '0;
                end
                SHIFT: if (tick) begin
                    if (sck) begin
                        // falling edge: next bit goes out while Sck is low
                        sck <= 1'b0;
                        if (bitn != LAST_BIT) begin
                            sdi <= sr[FRAME_BITS-2];
                            sr  <= {sr[FRAME_BITS-3:0], 1'b0};
                        end
                    end else if (bitn != LAST_BIT) begin
                        sck  <= 1'b1;
                        bitn <= bitn + 4'd1;
                    end
                end
                HOLD: if (tick) begin
                    cs  <= 1'b1;
                    sdi <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/res_pot_sched.sv
// Pot bus scheduler: arbitrates table loads vs single writes at frame boundaries.
// RES_POT_SHADOW_EN adds a shadow array that skips unchanged table channels.
module res_pot_sched
    import res_pot_pkg::*;
#(
    parameter int NCH     = 6,
    parameter int CLK_DIV = 2,
    parameter int GAP_CYC = 4
) (
    input  logic           OSC_in,
    input  logic           RstN,
    res_pot_sched_if.slave bus
);
    localparam logic [3:0] GAP_M1 = 4'(GAP_CYC - 1);

    pot_st_e                   st, st_n;
    logic [ADDR_BITS-1:0]      idx, tbl_ch, sgl_addr;
    logic [7:0][DATA_BITS-1:0] tbl_data;
    logic [DATA_BITS-1:0]      sgl_data;
    logic                      tbl_pend, sgl_pend, last_sgl, cur_sgl, tbl_ack, sgl_ack;
    logic [3:0]                gcnt;
    logic                      acc_t, acc_s, work, pick_sgl, tbl_found, more;
    logic                      start, done, launch_sgl, launch_tbl, skip_done;
    logic [FRAME_BITS-1:0]     frame;
    logic [NCH-1:0]            send;

    // Req is ignored in its own ack cycle; still high one cycle later is a new request.
    assign acc_t    = bus.TblReq && !tbl_pend && !tbl_ack;
    assign acc_s    = bus.SglReq && !sgl_pend && !sgl_ack;
    assign work     = tbl_pend || sgl_pend || acc_t || acc_s;
    assign pick_sgl = sgl_pend && !(last_sgl && tbl_pend);

    assign bus.TblAck = tbl_ack;
    assign bus.SglAck = sgl_ack;
    assign bus.Busy   = tbl_pend || sgl_pend;

    // Next channel to send at or after idx, and whether any remain after idx.
    always_comb begin
        tbl_found = 1'b0;
        tbl_ch    = idx;
        more      = 1'b0;
        for (int j = NCH - 1; j >= 0; j--)
            if (send[j] && j >= int'(idx)) begin
                tbl_found = 1'b1;
                tbl_ch    = 3'(j);
            end
        for (int j = 0; j < NCH; j++)
            if (send[j] && j > int'(idx)) more = 1'b1;
    end

    always_ff @(posedge OSC_in or negedge RstN)
        if (!RstN) st <= IDLE;
        else       st <= st_n;

    always_comb begin
        st_n       = st;
        start      = 1'b0;
        launch_sgl = 1'b0;
        launch_tbl = 1'b0;
        skip_done  = 1'b0;
        frame      = mk_frame(sgl_addr, sgl_data);
        case (st)
            IDLE: if (work) st_n = ARB;
            ARB: begin
                if (!work) begin
                    st_n = IDLE;
                end else if (pick_sgl) begin
                    if (bus.Win) begin
                        start      = 1'b1;
                        launch_sgl = 1'b1;
                        st_n       = SHIFT;
                    end
                end else if (tbl_pend) begin
                    if (!tbl_found) begin
                        skip_done = 1'b1;
                    end else if (bus.Win) begin
                        start      = 1'b1;
                        launch_tbl = 1'b1;
                        frame      = mk_frame(tbl_ch, tbl_data[tbl_ch]);
                        st_n       = SHIFT;
                    end
                end
            end
            SHIFT:   if (done) st_n = GAP;
            GAP:     if (gcnt == GAP_M1) st_n = work ? ARB : IDLE;
            default: st_n = IDLE;
        endcase
    end

    always_ff @(posedge OSC_in or negedge RstN) begin
        if (!RstN) begin
            idx      <= '0;
            tbl_data <= '0;
            sgl_addr <= '0;
            sgl_data <= '0;
            tbl_pend <= 1'b0;
            sgl_pend <= 1'b0;
            last_sgl <= 1'b0;
            cur_sgl  <= 1'b0;
            tbl_ack  <= 1'b0;
            sgl_ack  <= 1'b0;
            gcnt     <= '0;
        end else begin
            tbl_ack <= 1'b0;
            sgl_ack <= 1'b0;
            gcnt    <= (st == GAP) ? gcnt + 4'd1 : 4'd0;
            if (acc_t) begin
                tbl_pend <= 1'b1;
                for (int j = 0; j < NCH; j++) tbl_data[j] <= bus.TblData[8*j +: 8];
            end
            if (acc_s) begin
                sgl_pend <= 1'b1;
                sgl_addr <= bus.SglAddr;
                sgl_data <= bus.SglData;
            end
            if (launch_sgl) cur_sgl <= 1'b1;
            if (launch_tbl) begin
                cur_sgl <= 1'b0;
                idx     <= tbl_ch;
            end
            if (skip_done) begin
                tbl_ack  <= 1'b1;
                tbl_pend <= 1'b0;
                idx      <= '0;
            end
            if (done) begin
                last_sgl <= cur_sgl;
                if (cur_sgl) begin
                    sgl_ack  <= 1'b1;
                    sgl_pend <= 1'b0;
                end else if (more) begin
                    idx <= idx + 3'd1;
                end else begin
                    tbl_ack  <= 1'b1;
                    tbl_pend <= 1'b0;
                    idx      <= '0;
                end
            end
        end
    end

`ifdef RES_POT_SHADOW_EN
    logic [7:0][DATA_BITS-1:0] sh;
    logic [7:0]                sh_vld;
    logic [ADDR_BITS-1:0]      cur_addr;
    logic [DATA_BITS-1:0]      cur_data;

    assign cur_addr   = cur_sgl ? sgl_addr : idx;
    assign cur_data   = cur_sgl ? sgl_data : tbl_data[idx];
    assign bus.ShData = sh[bus.ShAddr];

    always_ff @(posedge OSC_in or negedge RstN) begin
        if (!RstN) begin
            sh     <= '0;
            sh_vld <= '0;
        end else if (done) begin
            sh[cur_addr]     <= cur_data;
            sh_vld[cur_addr] <= 1'b1;
        end
    end

    always_comb begin
        send = '1;
        for (int j = 0; j < NCH; j++)
            send[j] = !(sh_vld[j] && sh[j] == tbl_data[j]);
    end
`else
    assign send = '1;
`endif

    res_pot_shift #(.CLK_DIV(CLK_DIV)) u_shift (
        .gclk   (OSC_in),
        .grst_n (RstN),
        .start  (start),
        .frame  (frame),
        .done   (done),
        .cs     (bus.ResCS),
        .sck    (bus.ResSck),
        .sdi    (bus.ResSDI)
    );
endmodule

// File: tb/tb_res_pot_sched.sv
// Directed bench for res_pot_sched: a pin monitor rebuilds frames from ResCS/ResSck/ResSDI.
module tb_res_pot_sched;
    localparam int NCH = 6;
    localparam int DIV = 2;
    localparam int GAP = 4;

    logic OSC_in = 1'b0;
    logic RstN   = 1'b0;

    res_pot_sched_if #(.NCH(NCH)) bus ();

    res_pot_sched #(.NCH(NCH), .CLK_DIV(DIV), .GAP_CYC(GAP)) dut (
        .OSC_in (OSC_in),
        .RstN   (RstN),
        .bus    (bus)
    );

    always #5 OSC_in = ~OSC_in;

    typedef struct {
        logic [10:0] bits;
        int          nbits;
        int          cslow;
    } frm_t;

    frm_t        frames[$];
    logic [10:0] exp_q[$];
    int n_chk = 0, n_err = 0;
    int cs_falls = 0, cur_nbits = 0, cs_cnt = 0, hi_cnt = 0, min_gap = 1000;
    int tbl_ack_n = 0, sgl_ack_n = 0, tbl_ack_pos = 0, sgl_ack_pos = 0, sdi_glitch = 0;
    logic [10:0] cur_bits = '0;
    logic prev_cs = 1'b1, prev_sck = 1'b0, prev_sdi = 1'b0;

    // Pin monitor, sampled on the falling clock edge.
    always @(negedge OSC_in) begin
        if (!RstN) begin
            cur_nbits = 0;
            cs_cnt    = 0;
            cur_bits  = '0;
            prev_cs   = 1'b1;
            prev_sck  = 1'b0;
        end else begin
            if (!bus.ResCS) begin
                if (prev_cs) begin
                    cs_falls++;
                    if (hi_cnt < min_gap) min_gap = hi_cnt;
                    cur_nbits = 0;
                    cs_cnt    = 0;
                end
                cs_cnt++;
                if (bus.ResSck && !prev_sck) begin
                    cur_bits = {cur_bits[9:0], bus.ResSDI};
                    cur_nbits++;
                end
                if (bus.ResSck && prev_sck && bus.ResSDI !== prev_sdi) sdi_glitch++;
            end else begin
                if (!prev_cs) begin
                    frames.push_back('{cur_bits, cur_nbits, cs_cnt});
                    hi_cnt = 0;
                end
                hi_cnt++;
            end
            if (bus.TblAck) begin tbl_ack_n++; tbl_ack_pos = frames.size(); end
            if (bus.SglAck) begin sgl_ack_n++; sgl_ack_pos = frames.size(); end
            prev_cs  = bus.ResCS;
            prev_sck = bus.ResSck;
            prev_sdi = bus.ResSDI;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge OSC_in);
    endtask

    task automatic add_exp(input logic [2:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic chk_frames(input string tag);
        chk({tag, "_nframes"}, frames.size(), exp_q.size());
        for (int i = 0; i < frames.size() && i < exp_q.size(); i++) begin
            chk({tag, "_bits"},  frames[i].bits,  exp_q[i]);
            chk({tag, "_nbits"}, frames[i].nbits, 11);
            chk({tag, "_cslow"}, frames[i].cslow, 24 * DIV);
        end
        exp_q.delete();
    endtask

    task automatic wait_tbl(input string tag);
        int n0 = tbl_ack_n;
        bit ok = 1'b0;
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(negedge OSC_in); #1;
            if (tbl_ack_n != n0) ok = 1'b1;
        end
        chk({tag, "_tbl_ack_seen"}, ok, 1);
    endtask

    task automatic wait_sgl(input string tag);
        int n0 = sgl_ack_n;
        bit ok = 1'b0;
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(negedge OSC_in); #1;
            if (sgl_ack_n != n0) ok = 1'b1;
        end
        chk({tag, "_sgl_ack_seen"}, ok, 1);
    endtask

    task automatic wait_falls(input string tag, input int target);
        bit ok = 1'b0;
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(negedge OSC_in); #1;
            if (cs_falls >= target) ok = 1'b1;
        end
        chk({tag, "_cs_fall_seen"}, ok, 1);
    endtask

    initial begin
        int base, t0, s0;
        bit ok;
        bus.Win = 1'b1; bus.TblReq = 1'b0; bus.TblData = '0;
        bus.SglReq = 1'b0; bus.SglAddr = '0; bus.SglData = '0;
`ifdef RES_POT_SHADOW_EN
        bus.ShAddr = '0;
`endif
        idle(3); #1;
        chk("rst_cs",   bus.ResCS,  1);
        chk("rst_sck",  bus.ResSck, 0);
        chk("rst_sdi",  bus.ResSDI, 0);
        chk("rst_busy", bus.Busy,   0);
        chk("rst_acks", {bus.TblAck, bus.SglAck}, 0);
        #1 RstN = 1'b1;
        idle(3);

        // single write addr 5, data A3
        frames.delete();
        bus.SglAddr = 3'd5; bus.SglData = 8'hA3; bus.SglReq = 1'b1;
        idle(2); #1;
        chk("sgl_busy", bus.Busy, 1);
        wait_sgl("sgl");
        bus.SglReq = 1'b0;
        idle(30);
        exp_q.push_back(11'b101_1010_0011);
        chk_frames("sgl");
        chk("sgl_ack_cnt", sgl_ack_n, 1);
        chk("sgl_idle_busy", bus.Busy, 0);

        // full table load
        frames.delete(); min_gap = 1000; t0 = tbl_ack_n;
        bus.TblData = 48'hFF00CD200000; bus.TblReq = 1'b1;
        wait_tbl("tbl");
        bus.TblReq = 1'b0;
        idle(30);
        add_exp(0, 8'h00); add_exp(1, 8'h00); add_exp(2, 8'h20);
        add_exp(3, 8'hCD); add_exp(4, 8'h00); add_exp(5, 8'hFF);
        chk_frames("tbl");
        chk("tbl_ack_cnt", tbl_ack_n - t0, 1);
        chk("tbl_ack_pos", tbl_ack_pos, 6);
        chk("tbl_gap_min", min_gap >= GAP, 1);

        // single write lands between ch2 and ch3
        frames.delete(); base = cs_falls; t0 = tbl_ack_n; s0 = sgl_ack_n;
        bus.TblData = 48'h010203040506; bus.TblReq = 1'b1;
        wait_falls("mix", base + 3);
        bus.SglAddr = 3'd7; bus.SglData = 8'h11; bus.SglReq = 1'b1;
        wait_sgl("mix");
        bus.SglReq = 1'b0;
        wait_tbl("mix");
        bus.TblReq = 1'b0;
        idle(30);
        add_exp(0, 8'h06); add_exp(1, 8'h05); add_exp(2, 8'h04); add_exp(7, 8'h11);
        add_exp(3, 8'h03); add_exp(4, 8'h02); add_exp(5, 8'h01);
        chk_frames("mix");
        chk("mix_sgl_pos", sgl_ack_pos, 4);
        chk("mix_tbl_pos", tbl_ack_pos, 7);
        chk("mix_ack_cnt", {16'(tbl_ack_n - t0), 16'(sgl_ack_n - s0)}, {16'd1, 16'd1});

        // write window gating
        frames.delete(); base = cs_falls;
        bus.Win = 1'b0;
        bus.TblData = 48'h313233343536; bus.TblReq = 1'b1;
        idle(150); #1;
        chk("win0_no_cs", cs_falls - base, 0);
        chk("win0_busy", bus.Busy, 1);
        bus.Win = 1'b1;
        wait_falls("win", base + 1);
        bus.Win = 1'b0;
        idle(150);
        chk("win_mid_done",   frames.size(), 1);
        chk("win_mid_starts", cs_falls - base, 1);
        bus.Win = 1'b1;
        wait_tbl("win");
        bus.TblReq = 1'b0;
        idle(30);
        add_exp(0, 8'h36); add_exp(1, 8'h35); add_exp(2, 8'h34);
        add_exp(3, 8'h33); add_exp(4, 8'h32); add_exp(5, 8'h31);
        chk_frames("win");

        // reset mid-frame, then a clean frame
        frames.delete();
        bus.SglAddr = 3'd2; bus.SglData = 8'h5C; bus.SglReq = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge OSC_in); #1;
            if (!bus.ResCS && cur_nbits == 5) ok = 1'b1;
        end
        chk("rstmid_reached", ok, 1);
        RstN = 1'b0; bus.SglReq = 1'b0;
        #1;
        chk("rstmid_cs",   bus.ResCS,  1);
        chk("rstmid_sck",  bus.ResSck, 0);
        chk("rstmid_busy", bus.Busy,   0);
        idle(3);
        #2 RstN = 1'b1;
        idle(3);
        chk("rstmid_no_frame", frames.size(), 0);
        bus.SglReq = 1'b1;
        wait_sgl("post");
        bus.SglReq = 1'b0;
        idle(30);
        add_exp(2, 8'h5C);
        chk_frames("post");

`ifdef RES_POT_SHADOW_EN
        frames.delete();
        bus.TblData = 48'h414243444546; bus.TblReq = 1'b1;
        wait_tbl("sh1"); bus.TblReq = 1'b0; idle(30);
        add_exp(0, 8'h46); add_exp(1, 8'h45); add_exp(2, 8'h44);
        add_exp(3, 8'h43); add_exp(4, 8'h42); add_exp(5, 8'h41);
        chk_frames("sh1");
        frames.delete(); t0 = tbl_ack_n;
        bus.TblReq = 1'b1;
        wait_tbl("sh2"); bus.TblReq = 1'b0; idle(30);
        chk("sh2_frames", frames.size(), 0);
        chk("sh2_ack_cnt", tbl_ack_n - t0, 1);
        frames.delete();
        bus.TblData = 48'h414299444546; bus.TblReq = 1'b1;
        wait_tbl("sh3"); bus.TblReq = 1'b0; idle(30);
        add_exp(3, 8'h99);
        chk_frames("sh3");
        bus.ShAddr = 3'd3; #1;
        chk("sh_read3", bus.ShData, 8'h99);
`endif

        chk("sdi_stable_sck_high", sdi_glitch, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
